// File: rtl/ram_pkg.sv
// ram_pkg: shared state type, size-field width helper and default geometry for ram_burst.
package ram_pkg;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_MAX_BYTES  = 4;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  function automatic int size_w(input int max_bytes);
    return (max_bytes > 1) ? $clog2(max_bytes) : 1;
  endfunction
endpackage

// File: rtl/ram_byte_array.sv
// ram_byte_array: single-port byte RAM with registered read and no reset, so it maps to block RAM.
module ram_byte_array #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            data_i,
  output logic [7:0]            data_o
);
  logic [7:0] mem [2**ADDR_WIDTH];
  logic [7:0] data_q;
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= data_i;
    data_q <= mem[addr_i];
  end
  assign data_o = data_q;
endmodule

// File: rtl/ram_burst.sv
// ram_burst: sequences 1..MAX_BYTES little-endian byte accesses over ram_byte_array.
// Define RAM_BOUNDS_CHECK_EN to reject requests that run past the top of the array.
module ram_burst
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MAX_BYTES  = DEF_MAX_BYTES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          write_enable,
  input  logic [ADDR_WIDTH-1:0]         address,
  input  logic [size_w(MAX_BYTES)-1:0]  size,
  input  logic [8*MAX_BYTES-1:0]        data_in,
  output logic [8*MAX_BYTES-1:0]        data_out,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);
  localparam int SW = size_w(MAX_BYTES);
  localparam int KW = $clog2(MAX_BYTES) + 1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [SW-1:0]           size_q, size_d;
  logic [8*MAX_BYTES-1:0]  wdata_q, wdata_d, dout_q, dout_d;
  logic [KW-1:0]           k_q, k_d;
  logic                    err_q, err_d;
  logic                    oob, rd_accept, last_wr, last_rd;
  logic [7:0]              rdata;

`ifdef RAM_BOUNDS_CHECK_EN
  logic [ADDR_WIDTH:0] span;
  assign span = {1'b0, address} + (ADDR_WIDTH+1)'(size);
  assign oob  = span[ADDR_WIDTH];
`else
  assign oob = 1'b0;
`endif

  assign rd_accept = state_q == IDLE && start && !write_enable && !oob;
  assign last_wr   = k_q == KW'(size_q);
  // reads run one extra cycle because the array output is registered
  assign last_rd   = k_q == KW'(size_q) + KW'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    err_d   = err_q;
    k_d     = k_q + KW'(1);
    case (state_q)
      IDLE: begin
        k_d = '0;
        if (start) begin
          addr_d  = address;
          size_d  = size;
          wdata_d = data_in;
          err_d   = oob;
          state_d = oob ? DONE : write_enable ? WRITE : READ;
        end
      end
      WRITE: begin
        wdata_d = wdata_q >> 8;
        state_d = last_wr ? DONE : WRITE;
      end
      READ:    state_d = last_rd ? DONE : READ;
      default: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
    endcase
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (rd_accept && i > int'(size)) dout_d[8*i +: 8] = '0;
      if (state_q == READ && int'(k_q) == i + 1) dout_d[8*i +: 8] = rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      k_q     <= k_d;
    end
  end

  ram_byte_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk    (clk),
    .we_i   (state_q == WRITE),
    .addr_i (addr_q + ADDR_WIDTH'(k_q)),
    .data_i (wdata_q[7:0]),
    .data_o (rdata)
  );

  assign data_out = dout_q;
  assign busy     = state_q == WRITE || state_q == READ;
  assign done     = state_q == DONE;
  assign error    = done && err_q;
endmodule

// File: tb/tb_ram_burst.sv
// tb_ram_burst: directed tests for ram_burst with hand-computed expectations.
module tb_ram_burst;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        write_enable = 1'b0;
  logic [11:0] address = '0;
  logic [1:0]  size = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        busy, done, error;
  int checks = 0;
  int failures = 0;
  int lat;
  bit got, berr, bbusy;

  always #5 clk = ~clk;

  ram_burst #(.ADDR_WIDTH(12), .MAX_BYTES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .write_enable(write_enable),
    .address(address), .size(size), .data_in(data_in),
    .data_out(data_out), .busy(busy), .done(done), .error(error)
  );

  // issue one request from IDLE; return latency (edges after E0 until done seen) and leave in IDLE
  task automatic run(input bit we, input logic [11:0] a, input logic [1:0] sz, input logic [31:0] d);
    start = 1'b1; write_enable = we; address = a; size = sz; data_in = d;
    @(posedge clk); #1;
    start = 1'b0;
    bbusy = busy; got = 1'b0; lat = -1; berr = 1'b0;
    if (done) begin got = 1'b1; lat = 0; berr = error; end
    for (int j = 1; j <= 20 && !got; j++) begin
      @(posedge clk); #1;
      if (done) begin got = 1'b1; lat = j; berr = error; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL rst_error got=%b exp=0", error); end
    checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=00000000", data_out); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    run(1'b1, 12'h100, 2'd3, 32'h44332211);
    checks++; if (lat !== 4) begin failures++; $display("FAIL wr4_latency got=%0d exp=4", lat); end
    checks++; if (bbusy !== 1'b1) begin failures++; $display("FAIL wr4_busy got=%b exp=1", bbusy); end
    checks++; if (berr !== 1'b0) begin failures++; $display("FAIL wr4_error got=%b exp=0", berr); end
    run(1'b0, 12'h100, 2'd3, 32'h0);
    checks++; if (lat !== 5) begin failures++; $display("FAIL rd4_latency got=%0d exp=5", lat); end
    checks++; if (data_out !== 32'h44332211) begin failures++; $display("FAIL rd4_data got=%h exp=44332211", data_out); end
  endtask

  task automatic test_partial_reads;
    run(1'b0, 12'h102, 2'd0, 32'h0);
    checks++; if (data_out !== 32'h00000033) begin failures++; $display("FAIL rd1_data got=%h exp=00000033", data_out); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL rd1_latency got=%0d exp=2", lat); end
    run(1'b0, 12'h101, 2'd1, 32'h0);
    checks++; if (data_out !== 32'h00003322) begin failures++; $display("FAIL rd2_data got=%h exp=00003322", data_out); end
  endtask

  task automatic test_start_spam;
    int nd = 0;
    start = 1'b1; write_enable = 1'b0; address = 12'h100; size = 2'd3; data_in = 32'h0;
    @(posedge clk); #1;
    write_enable = 1'b1; data_in = 32'hFFFFFFFF;
    lat = -1;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
      if (done) begin nd++; if (lat < 0) lat = j; start = 1'b0; end
    end
    start = 1'b0;
    checks++; if (nd !== 1) begin failures++; $display("FAIL spam_done_count got=%0d exp=1", nd); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL spam_latency got=%0d exp=5", lat); end
    checks++; if (data_out !== 32'h44332211) begin failures++; $display("FAIL spam_data got=%h exp=44332211", data_out); end
    run(1'b0, 12'h100, 2'd3, 32'h0);
    checks++; if (data_out !== 32'h44332211) begin failures++; $display("FAIL spam_mem got=%h exp=44332211", data_out); end
  endtask

  task automatic test_reset_mid;
    int nd = 0;
    run(1'b1, 12'h200, 2'd3, 32'h0);
    start = 1'b1; write_enable = 1'b1; address = 12'h200; size = 2'd3; data_in = 32'hDDCCBBAA;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
    checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL midrst_data got=%h exp=00000000", data_out); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    checks++; if (nd !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", nd); end
    run(1'b0, 12'h200, 2'd3, 32'h0);
    checks++; if (data_out !== 32'h0000BBAA) begin failures++; $display("FAIL midrst_mem got=%h exp=0000BBAA", data_out); end
  endtask

  task automatic test_top_of_array;
`ifdef RAM_BOUNDS_CHECK_EN
    run(1'b1, 12'hFFC, 2'd3, 32'h0);
    run(1'b1, 12'h000, 2'd1, 32'h0000BEEF);
    run(1'b0, 12'h000, 2'd1, 32'h0);
    run(1'b1, 12'hFFE, 2'd3, 32'h87654321);
    checks++; if (lat !== 0) begin failures++; $display("FAIL oob_latency got=%0d exp=0", lat); end
    checks++; if (berr !== 1'b1) begin failures++; $display("FAIL oob_error got=%b exp=1", berr); end
    checks++; if (bbusy !== 1'b0) begin failures++; $display("FAIL oob_busy got=%b exp=0", bbusy); end
    checks++; if (data_out !== 32'h0000BEEF) begin failures++; $display("FAIL oob_data_held got=%h exp=0000BEEF", data_out); end
    run(1'b0, 12'hFFF, 2'd1, 32'h0);
    checks++; if (berr !== 1'b1) begin failures++; $display("FAIL oob_rd_error got=%b exp=1", berr); end
    checks++; if (data_out !== 32'h0000BEEF) begin failures++; $display("FAIL oob_rd_data got=%h exp=0000BEEF", data_out); end
    run(1'b0, 12'hFFC, 2'd3, 32'h0);
    checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL oob_top_mem got=%h exp=00000000", data_out); end
    checks++; if (berr !== 1'b0) begin failures++; $display("FAIL inrange_error got=%b exp=0", berr); end
    run(1'b0, 12'h000, 2'd1, 32'h0);
    checks++; if (data_out !== 32'h0000BEEF) begin failures++; $display("FAIL oob_low_mem got=%h exp=0000BEEF", data_out); end
`else
    run(1'b1, 12'hFFE, 2'd3, 32'h87654321);
    checks++; if (lat !== 4) begin failures++; $display("FAIL wrap_wr_latency got=%0d exp=4", lat); end
    checks++; if (berr !== 1'b0) begin failures++; $display("FAIL wrap_error got=%b exp=0", berr); end
    run(1'b0, 12'hFFE, 2'd1, 32'h0);
    checks++; if (data_out !== 32'h00004321) begin failures++; $display("FAIL wrap_top got=%h exp=00004321", data_out); end
    run(1'b0, 12'h000, 2'd1, 32'h0);
    checks++; if (data_out !== 32'h00008765) begin failures++; $display("FAIL wrap_low got=%h exp=00008765", data_out); end
    run(1'b0, 12'hFFE, 2'd3, 32'h0);
    checks++; if (data_out !== 32'h87654321) begin failures++; $display("FAIL wrap_rd4 got=%h exp=87654321", data_out); end
`endif
  endtask

  task automatic test_back_to_back;
    run(1'b1, 12'h300, 2'd1, 32'h00005A5A);
    checks++; if (lat !== 2) begin failures++; $display("FAIL b2b_wr_latency got=%0d exp=2", lat); end
    run(1'b0, 12'h300, 2'd1, 32'h0);
    checks++; if (bbusy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", bbusy); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL b2b_rd_latency got=%0d exp=3", lat); end
    checks++; if (data_out !== 32'h00005A5A) begin failures++; $display("FAIL b2b_data got=%h exp=00005A5A", data_out); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_reads();
    test_start_spam();
    test_reset_mid();
    test_top_of_array();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
